// File: rtl/mux_stream_sel_if.sv
// rtl/mux_stream_sel_if.sv - handshake bundle between producers, mux and consumer
interface mux_stream_sel_if #(
  parameter int NCH = 16,
  parameter int W   = 8
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic             mode;
  logic [SELW-1:0]  sel;
  logic [W-1:0]     out_data;
  logic [SELW-1:0]  out_ch;
  logic             out_valid;
  logic             out_ready;

  // Environment side: drives producers, mode/sel and consumer ready
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  // Mux side
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_stream_sel.sv
// rtl/mux_stream_sel.sv - N-channel streaming mux, fixed or round-robin select, registered output
module mux_stream_sel #(
  parameter int NCH = 16,
  parameter int W   = 8
) (
  input logic             clk,
  input logic             rst,
  mux_stream_sel_if.slave bus
);
  localparam int SELW = $clog2(NCH);

  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_ch;
  logic            r_out_valid;
  logic [SELW-1:0] r_rr_ptr;

  logic            w_load;
  logic            w_fix_valid;
  logic            w_rr_valid;
  logic [SELW-1:0] w_rr_grant;
  logic [SELW-1:0] w_cand;
  logic            w_grant_valid;
  logic [SELW-1:0] w_grant;
  logic            w_xfer;

  // Output register can take a beat when empty or being drained this cycle
  assign w_load = !r_out_valid || bus.out_ready;

  // Fixed select: out-of-range sel never grants
  assign w_fix_valid = (int'(bus.sel) < NCH) && bus.in_valid[bus.sel];

  // Round-robin search starting just after the last served channel; the
  // descending loop lets the nearest candidate overwrite farther ones
  always_comb begin
    w_rr_valid = 1'b0;
    w_rr_grant = '0;
    w_cand     = '0;
    for (int k = NCH; k >= 1; k--) begin
      w_cand = SELW'((int'(r_rr_ptr) + k) % NCH);
      if (bus.in_valid[w_cand]) begin
        w_rr_grant = w_cand;
        w_rr_valid = 1'b1;
      end
    end
  end

  assign w_grant_valid = bus.mode ? w_rr_valid : w_fix_valid;
  assign w_grant       = bus.mode ? w_rr_grant : bus.sel;
  assign w_xfer        = w_load && w_grant_valid;

  // One-hot ready to the granted channel, forced low while in reset
  always_comb begin
    bus.in_ready = '0;
    if (!rst && w_xfer) begin
      bus.in_ready[w_grant] = 1'b1;
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= SELW'(NCH - 1);
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.in_data[int'(w_grant)*W +: W];
        r_out_ch    <= w_grant;
        if (bus.mode) begin
          r_rr_ptr <= w_grant;
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_mux_stream_sel.sv
// tb/tb_mux_stream_sel.sv - directed self-checking bench for mux_stream_sel
module tb_mux_stream_sel;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_stream_sel_if #(.NCH(16), .W(8)) bus16 ();
  mux_stream_sel_if #(.NCH(4),  .W(1)) bus4 ();

  mux_stream_sel #(.NCH(16), .W(8)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  mux_stream_sel #(.NCH(4),  .W(1)) dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fill_data;
    for (int i = 0; i < 16; i++) bus16.in_data[i*8 +: 8] = 8'(8'hA0 + i);
  endtask

  task automatic test_reset;
    bus16.mode = 1'b0; bus16.sel = 4'd0; bus16.in_valid = 16'hFFFF; bus16.out_ready = 1'b1;
    fill_data();
    bus4.mode = 1'b0; bus4.sel = 2'd0; bus4.in_valid = 4'h0; bus4.out_ready = 1'b1;
    bus4.in_data = 4'b1010;
    #2;
    chk("reset_out_valid", 32'(bus16.out_valid), 32'd0);
    chk("reset_out_data", 32'(bus16.out_data), 32'd0);
    chk("reset_out_ch", 32'(bus16.out_ch), 32'd0);
    chk("reset_in_ready", 32'(bus16.in_ready), 32'd0);
    chk("reset_small_valid", 32'(bus4.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fixed_walk;
    for (int s = 0; s < 16; s++) begin
      bus16.sel = 4'(s);
      #1;
      chk("fixed_in_ready", 32'(bus16.in_ready), 32'(16'd1 << s));
      step();
      chk("fixed_data", 32'(bus16.out_data), 32'(8'hA0 + s));
      chk("fixed_ch", 32'(bus16.out_ch), 32'(s));
      chk("fixed_valid", 32'(bus16.out_valid), 32'd1);
    end
  endtask

  task automatic test_no_valid;
    bus16.sel = 4'd5;
    bus16.in_valid = 16'hFFDF;
    #1;
    chk("novalid_in_ready", 32'(bus16.in_ready), 32'd0);
    step();
    chk("novalid_out_valid_a", 32'(bus16.out_valid), 32'd0);
    step();
    chk("novalid_out_valid_b", 32'(bus16.out_valid), 32'd0);
    bus16.sel = 4'hF;
    #1;
    chk("sel15_in_ready", 32'(bus16.in_ready), 32'h8000);
    step();
    chk("sel15_data", 32'(bus16.out_data), 32'hAF);
    chk("sel15_ch", 32'(bus16.out_ch), 32'd15);
    chk("sel15_valid", 32'(bus16.out_valid), 32'd1);
  endtask

  task automatic test_rr_all;
    bus16.mode = 1'b1;
    bus16.in_valid = 16'hFFFF;
    bus16.out_ready = 1'b1;
    do_reset();
    for (int j = 0; j < 17; j++) begin
      step();
      chk("rr_all_ch", 32'(bus16.out_ch), 32'(j % 16));
      chk("rr_all_data", 32'(bus16.out_data), 32'(8'hA0 + (j % 16)));
      chk("rr_all_valid", 32'(bus16.out_valid), 32'd1);
    end
  endtask

  task automatic test_rr_wrap;
    int exp_ch [4] = '{0, 15, 0, 15};
    bus16.mode = 1'b1;
    bus16.in_valid = 16'h0000;
    do_reset();
    bus16.in_valid = 16'h8001;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("rr_wrap_in_ready", 32'(bus16.in_ready), 32'(16'd1 << exp_ch[j]));
      step();
      chk("rr_wrap_ch", 32'(bus16.out_ch), 32'(exp_ch[j]));
    end
  endtask

  task automatic test_backpressure;
    bus16.mode = 1'b0;
    bus16.sel = 4'd3;
    bus16.in_valid = 16'hFFFF;
    bus16.out_ready = 1'b0;
    do_reset();
    bus16.in_data[3*8 +: 8] = 8'h3C;
    #1;
    chk("bp_first_ready", 32'(bus16.in_ready), 32'h0008);
    step();
    chk("bp_first_data", 32'(bus16.out_data), 32'h3C);
    bus16.in_data[3*8 +: 8] = 8'h3D;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_hold_ready", 32'(bus16.in_ready), 32'd0);
      step();
      chk("bp_hold_data", 32'(bus16.out_data), 32'h3C);
      chk("bp_hold_ch", 32'(bus16.out_ch), 32'd3);
      chk("bp_hold_valid", 32'(bus16.out_valid), 32'd1);
    end
    bus16.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus16.in_ready), 32'h0008);
    step();
    chk("bp_next_data", 32'(bus16.out_data), 32'h3D);
    chk("bp_next_valid", 32'(bus16.out_valid), 32'd1);
    bus16.in_valid = 16'h0000;
    step();
    chk("bp_drained_valid", 32'(bus16.out_valid), 32'd0);
    fill_data();
  endtask

  task automatic test_async_reset;
    bus16.mode = 1'b1;
    bus16.in_valid = 16'hFFFF;
    bus16.out_ready = 1'b1;
    do_reset();
    step(); step(); step();
    chk("ar_pre_ch", 32'(bus16.out_ch), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(bus16.out_valid), 32'd0);
    chk("ar_in_ready", 32'(bus16.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("ar_restart_ch", 32'(bus16.out_ch), 32'd0);
    step();
    chk("ar_restart_ch1", 32'(bus16.out_ch), 32'd1);
  endtask

  task automatic test_small;
    int exp_ch [5] = '{0, 1, 2, 3, 0};
    logic [3:0] d;
    d = 4'b1010;
    bus16.in_valid = 16'h0000;
    bus4.mode = 1'b1;
    bus4.in_valid = 4'hF;
    bus4.out_ready = 1'b1;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      step();
      chk("small_pre_ch", 32'(bus4.out_ch), 32'(j));
    end
    #2;
    rst = 1'b1;
    #1;
    chk("small_ar_valid", 32'(bus4.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("small_ch", 32'(bus4.out_ch), 32'(exp_ch[j]));
      chk("small_data", 32'(bus4.out_data), 32'(d[exp_ch[j]]));
      chk("small_valid", 32'(bus4.out_valid), 32'd1);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_walk();
    test_no_valid();
    test_rr_all();
    test_rr_wrap();
    test_backpressure();
    test_async_reset();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
